systolic_feed_ctrl: RTL and testbench
=====================================

// Module: systolic_feed_ctrl
// PURPOSE
//  Sequencer that drives the 4-input systolic array (systolic_2: start, x01..x04).
//  On a go request it fetches cfg_rows consecutive 4-word rows from a row memory,
//  presents them one row per cycle with a start pulse aligned to row 0, then idles
//  the inputs for a drain window while results flush, and signals done.
//  Replaces the hand-driven feed/start sequencing around the array.
// PARAMETERS
//  DATA_W        32   width of each array input word x01..x04
//  ADDR_W        4    row-memory address width; max job = 2**ADDR_W rows
//  DRAIN_CYCLES  50   zero-input cycles after the last row before done (>=1)
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  go         in   1          job request, sampled only when busy=0
//  abort      in   1          cancel running job (ignored when idle)
//  cfg_rows   in   ADDR_W+1   rows in job, latched on accepted go
//  cfg_base   in   ADDR_W     first row address, latched on accepted go
//  busy       out  1          job in progress
//  done       out  1          one-cycle pulse: job completed normally
//  mem_rd     out  1          row-memory read enable (registered)
//  mem_addr   out  ADDR_W     row-memory address (registered)
//  mem_x1..4  in   DATA_W     row data, valid the cycle after memory samples mem_rd
//  sa_start   out  1          start pulse to array
//  sa_x01..04 out  DATA_W     array inputs (registered)
// BEHAVIOUR
//  - Reset: busy, done, mem_rd, sa_start = 0; mem_addr, sa_x01..04 = 0; FSM IDLE.
//  - FSM: IDLE -> FETCH -> FEED -> DRAIN -> DONE -> IDLE.
//  - Edge numbering: edge 0 = edge sampling go=1 in IDLE.
//  - Edge 0: latch N = min(cfg_rows, 2**ADDR_W), base; busy=1; if N=0 go to DONE
//    directly (no reads, no sa_start), else mem_rd=1, mem_addr=base, FETCH.
//  - mem_rd stays 1 for N consecutive cycles, mem_addr = base+r (mod 2**ADDR_W,
//    wraps), r=0..N-1; mem_rd=0 after edge N.
//  - Edge 2+r (r=0..N-1): sa_x0k <= mem_xk; sa_start=1 only for r=0 (one cycle).
//  - Edge 2+N: sa_x* <= 0, enter DRAIN; hold zero for DRAIN_CYCLES cycles.
//  - Edge 2+N+DRAIN_CYCLES: done=1 for one cycle (DONE); next edge busy=0, IDLE.
//  - N=0: done=1 after edge 1, busy=0 after edge 2.
//  - go while busy=1 (incl. DONE cycle): ignored, not queued.
//  - go accepted in the cycle right after busy falls.
//  - abort=1 while busy: next edge IDLE, busy=0, mem_rd=0, sa_start=0, sa_x*=0,
//    no done; in-flight memory data discarded. abort and go same cycle in IDLE: go wins.
//  - rst mid-job: identical to reset values at that edge; no done.
//  - Counters: row counter ADDR_W+1 bits, drain counter ceil(log2(DRAIN_CYCLES+1)).
// TESTING
//  1 rst=1 two cycles -> busy=done=mem_rd=sa_start=0, sa_x*=0, mem_addr=0.
//  2 cfg_rows=10,cfg_base=0,mem row r = {r,r+16,r+32,r+48} -> mem_addr 0..9,
//    sa_start only at edge 2 with sa_x01=0; rows 0..9 at edges 2..11; zeros 12..61;
//    done at edge 62 only; busy=0 from edge 63.
//  3 ADDR_W=4, cfg_base=14, cfg_rows=4 -> mem_addr 14,15,0,1; sa_x01 = rows 14,15,0,1.
//  4 cfg_rows=0 -> no mem_rd, no sa_start, done at edge 1, busy low after edge 2;
//    cfg_rows=20 with ADDR_W=4 -> exactly 16 rows fed.
//  5 go held high through job -> exactly one job; abort at row 3 -> sa_x*=0 next
//    edge, no done, busy=0; new go next cycle starts clean job at cfg_base.
//  6 rst pulse during DRAIN -> all outputs reset next edge, no done pulse.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_feed_ctrl
//
// Sequencer for the 4-input systolic array. When a job is requested it reads
// up to 2**ADDR_W consecutive 4-word rows from a row memory. It presents the
// rows to the array one per cycle and pulses sa_start with row 0. It then
// drives zeros for DRAIN_CYCLES cycles while the array flushes, and finally
// pulses done.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   go, abort            job request (accepted when idle) / cancel running job
//   cfg_rows, cfg_base   job length and first row address, latched on go
//   busy, done           job in progress / one-cycle completion pulse
//   mem_rd, mem_addr     registered row-memory read request
//   mem_x1..mem_x4       row data, valid the cycle after the memory samples rd
//   sa_start             start pulse to the array, aligned with row 0
//   sa_x01..sa_x04       registered array inputs
// -----------------------------------------------------------------------------
module systolic_feed_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W:0]   cfg_rows,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_x1,
  input  logic [DATA_W-1:0] mem_x2,
  input  logic [DATA_W-1:0] mem_x3,
  input  logic [DATA_W-1:0] mem_x4,
  output logic              sa_start,
  output logic [DATA_W-1:0] sa_x01,
  output logic [DATA_W-1:0] sa_x02,
  output logic [DATA_W-1:0] sa_x03,
  output logic [DATA_W-1:0] sa_x04
);

  localparam int RW = ADDR_W + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [RW-1:0] MAX_ROWS   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, FEED, DRAIN, DONE_S} state_t;

  // Clamp a requested job length to the size of the row memory.
  function automatic logic [RW-1:0] sat_rows(input logic [RW-1:0] req);
    return (req > MAX_ROWS) ? MAX_ROWS : req;
  endfunction

  state_t          state;
  logic [RW-1:0]   n_rows;
  logic [RW-1:0]   row_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            st_p0;
  logic            st_p1;
  logic            vld_p1;
  logic [RW-1:0]   go_rows;

  assign go_rows = sat_rows(cfg_rows);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      n_rows    <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      st_p0     <= 1'b0;
      st_p1     <= 1'b0;
      vld_p1    <= 1'b0;
      sa_start  <= 1'b0;
      sa_x01    <= '0;
      sa_x02    <= '0;
      sa_x03    <= '0;
      sa_x04    <= '0;
    end else if (abort && state != IDLE) begin
      // Cancel: drop the read stream and any row still in flight.
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      st_p0    <= 1'b0;
      st_p1    <= 1'b0;
      vld_p1   <= 1'b0;
      sa_start <= 1'b0;
      sa_x01   <= '0;
      sa_x02   <= '0;
      sa_x03   <= '0;
      sa_x04   <= '0;
    end else begin
      // p0 -> p1: read request becomes memory-data-valid one cycle later
      vld_p1   <= mem_rd;
      st_p1    <= st_p0;
      st_p0    <= 1'b0;
      // p1 -> array: capture the row, or drive zeros between/after rows
      sa_start <= st_p1;
      if (vld_p1) begin
        sa_x01 <= mem_x1;
        sa_x02 <= mem_x2;
        sa_x03 <= mem_x3;
        sa_x04 <= mem_x4;
      end else begin
        sa_x01 <= '0;
        sa_x02 <= '0;
        sa_x03 <= '0;
        sa_x04 <= '0;
      end

      case (state)
        IDLE: begin
          if (go) begin
            busy   <= 1'b1;
            n_rows <= go_rows;
            if (go_rows == '0) begin
              // Empty job: DONE_S is entered with done low so the pulse
              // lands one cycle later.
              state <= DONE_S;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= cfg_base;
              row_cnt  <= RW'(1);
              st_p0    <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (row_cnt == n_rows) begin
            mem_rd <= 1'b0;
            state  <= FEED;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            row_cnt  <= row_cnt + RW'(1);
          end
        end
        FEED: begin
          // Leave once the last row has been captured into sa_x*.
          if (!vld_p1) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            done  <= 1'b1;
            state <= DONE_S;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE_S: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_feed_ctrl
//
// Directed bench for systolic_feed_ctrl with a behavioural row memory in which
// row a holds {a, a+16, a+32, a+48}. Expected rows are queued when a job is
// launched and popped as the array inputs present them.
// -----------------------------------------------------------------------------
module tb_systolic_feed_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int D      = 50;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [4*DATA_W-1:0] row_t;

  logic              clk;
  logic              rst;
  logic              go;
  logic              abort;
  logic [ADDR_W:0]   cfg_rows;
  logic [ADDR_W-1:0] cfg_base;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_x1, mem_x2, mem_x3, mem_x4;
  logic              sa_start;
  logic [DATA_W-1:0] sa_x01, sa_x02, sa_x03, sa_x04;

  int   errors = 0;
  int   checks = 0;
  row_t exp_q[$];

  systolic_feed_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_base(cfg_base),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x1(mem_x1), .mem_x2(mem_x2), .mem_x3(mem_x3), .mem_x4(mem_x4),
    .sa_start(sa_start),
    .sa_x01(sa_x01), .sa_x02(sa_x02), .sa_x03(sa_x03), .sa_x04(sa_x04)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_x1 <= DATA_W'(mem_addr);
      mem_x2 <= DATA_W'(mem_addr) + 16;
      mem_x3 <= DATA_W'(mem_addr) + 32;
      mem_x4 <= DATA_W'(mem_addr) + 48;
    end
  end

  function automatic row_t row_of(input int a);
    int m;
    m = a % DEPTH;
    return {DATA_W'(m), DATA_W'(m + 16), DATA_W'(m + 32), DATA_W'(m + 48)};
  endfunction

  function automatic row_t sa_obs();
    return {sa_x01, sa_x02, sa_x03, sa_x04};
  endfunction

  task automatic chk(input string tag, input row_t obs, input row_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a job and check every edge until one cycle after busy should fall.
  task automatic run_job(input int rows, input int base, input string name);
    int n;
    int de;
    row_t exp;
    n  = (rows > DEPTH) ? DEPTH : rows;
    de = (n == 0) ? 1 : n + 2 + D;
    for (int r = 0; r < n; r++) exp_q.push_back(row_of(base + r));
    @(negedge clk);
    cfg_rows = (ADDR_W+1)'(rows);
    cfg_base = ADDR_W'(base);
    go       = 1'b1;
    step();
    go = 1'b0;
    for (int e = 0; e <= de + 1; e++) begin
      if (e > 0) step();
      chk({name, "_ctl"}, row_t'({busy, done, mem_rd, sa_start}),
          row_t'({e <= de, e == de, e < n, (n > 0) && (e == 2)}));
      if (e < n)
        chk({name, "_addr"}, row_t'(mem_addr), row_t'((base + e) % DEPTH));
      if (e >= 2 && e < n + 2) begin
        if (exp_q.size() == 0) begin
          exp = '1;
        end else begin
          exp = exp_q.pop_front();
        end
        chk({name, "_row"}, sa_obs(), exp);
      end else begin
        chk({name, "_zero"}, sa_obs(), row_t'(0));
      end
    end
    chk({name, "_qempty"}, row_t'(exp_q.size()), row_t'(0));
  endtask

  initial begin
    int   starts;
    int   dones;
    int   late;
    logic seen;
    logic found;

    rst = 1'b1; go = 1'b0; abort = 1'b0; cfg_rows = '0; cfg_base = '0;

    // Reset state
    step();
    step();
    chk("reset_ctl", row_t'({busy, done, mem_rd, sa_start}), row_t'(0));
    chk("reset_addr", row_t'(mem_addr), row_t'(0));
    chk("reset_data", sa_obs(), row_t'(0));
    @(negedge clk);
    rst = 1'b0;

    // Basic job, wrapped addressing, empty job, oversize job
    run_job(10, 0, "job10");
    run_job(4, 14, "wrap");
    run_job(0, 3, "empty");
    run_job(20, 0, "sat16");

    // go held high for the whole job: exactly one job
    @(negedge clk);
    cfg_rows = 5'd3; cfg_base = 4'd2; go = 1'b1;
    starts = 0; dones = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sa_start) starts++;
      if (done) dones++;
      if (busy) seen = 1'b1;
      if (seen && !busy) break;
    end
    go = 1'b0;
    chk("hold_seen", row_t'(seen), row_t'(1));
    chk("hold_starts", row_t'(starts), row_t'(1));
    chk("hold_dones", row_t'(dones), row_t'(1));
    late = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy) late++;
    end
    chk("hold_idle", row_t'(late), row_t'(0));

    // Abort at row 3, then an immediate clean job
    exp_q.delete();
    @(negedge clk);
    cfg_rows = 5'd10; cfg_base = 4'd0; go = 1'b1;
    step();
    go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sa_x01 == 3 && sa_x02 == 19) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("abort_found", row_t'(found), row_t'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ctl", row_t'({busy, done, mem_rd, sa_start}), row_t'(0));
    chk("abort_data", sa_obs(), row_t'(0));
    run_job(3, 5, "after_abort");

    // Reset pulse during drain
    @(negedge clk);
    cfg_rows = 5'd2; cfg_base = 4'd0; go = 1'b1;
    step();
    go = 1'b0;
    repeat (14) step();
    chk("drain_busy", row_t'(busy), row_t'(1));
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_ctl", row_t'({busy, done, mem_rd, sa_start}), row_t'(0));
    chk("rst_addr", row_t'(mem_addr), row_t'(0));
    chk("rst_data", sa_obs(), row_t'(0));
    late = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done || busy) late++;
    end
    chk("rst_no_done", row_t'(late), row_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
